// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA transmitter: register offsets,
// status bit positions and the shifter state encoding.
package acia_pkg;

  // Register select values on A0
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  // Bit positions inside the status byte
  localparam int ST_TDRE = 0;
  localparam int ST_IDLE = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_IRQ  = 7;

  // Serial shifter states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: a down-counter that is reloaded on every shifter state
// entry and flags the last E cycle of the current bit period.
module baud_tick #(
  parameter int DIV = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam logic [11:0] LAST = 12'(DIV - 1);

  logic [11:0] cnt_q;
  logic [11:0] cnt_d;

  // Next count: reload to DIV-1 on request, otherwise count down and wrap
  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = LAST;
    end else if (cnt_q == 12'd0) begin
      cnt_d = LAST;
    end else begin
      cnt_d = cnt_q - 12'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 12'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count marks the final cycle of a bit period
  assign tick = (cnt_q == 12'd0);

endmodule

// File: rtl/acia_tx.sv
// Memory-mapped 8N1/8N2 serial transmitter with a one-deep holding
// register, pollable status and an active-low interrupt request.
module acia_tx
  import acia_pkg::*;
#(
  parameter int DIV       = 104,
  parameter int STOP_BITS = 1
) (
  input  logic       E,
  input  logic       RESET,
  input  logic       CS,
  input  logic       RW,
  input  logic       A0,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       TXD,
  output logic       IRQ
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       tdre_q, tdre_d;
  logic       ie_q, ie_d;
  logic       ovr_q, ovr_d;
  logic       txd_q, txd_d;
  logic       irq_q, irq_d;

  logic       tick;
  logic       reload;
  logic       load;
  logic       last_stop;
  logic       wr_data;
  logic       wr_ctrl;
  logic       rd_status;
  logic [7:0] status;

  // Bus decode: writes and the status read act on the E rising edge
  assign wr_data   = CS & ~RW & (A0 == REG_DATA);
  assign wr_ctrl   = CS & ~RW & (A0 == REG_CTRL);
  assign rd_status = CS &  RW & (A0 == REG_CTRL);

  // The holding byte moves into the shifter when the line is free or the
  // final stop cycle ends, so back-to-back frames have no idle gap
  assign last_stop = (state_q == STOP) && tick && (bit_cnt_q == LAST_STOP);
  assign load      = ~tdre_q && ((state_q == IDLE) || last_stop);
  assign reload    = load || ((state_q != IDLE) && tick);

  baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .clk   (E),
    .rst_n (RESET),
    .reload(reload),
    .tick  (tick)
  );

  // Status byte assembly
  always_comb begin
    status          = 8'h00;
    status[ST_TDRE] = tdre_q;
    status[ST_IDLE] = (state_q == IDLE) && tdre_q;
    status[ST_OVR]  = ovr_q;
    status[ST_IRQ]  = ie_q & tdre_q;
  end

  // Only the status register reads back; the data register reads as zero
  assign DOUT = rd_status ? status : 8'h00;

  // Holding register, enable and overrun next-state; a write coinciding
  // with a transfer lands in the freshly emptied holding register
  always_comb begin
    hold_d = hold_q;
    tdre_d = tdre_q;
    ovr_d  = ovr_q;
    ie_d   = ie_q;
    if (load) begin
      tdre_d = 1'b1;
    end
    if (wr_data) begin
      if (tdre_q || load) begin
        hold_d = DIN;
        tdre_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (wr_ctrl) begin
      ie_d = DIN[0];
    end
    if (rd_status) begin
      ovr_d = 1'b0;
    end
    irq_d = ~(ie_q & tdre_q);
  end

  // Bus-side registers
  always_ff @(posedge E or negedge RESET) begin
    if (!RESET) begin
      hold_q <= 8'h00;
      tdre_q <= 1'b1;
      ovr_q  <= 1'b0;
      ie_q   <= 1'b0;
      irq_q  <= 1'b1;
    end else begin
      hold_q <= hold_d;
      tdre_q <= tdre_d;
      ovr_q  <= ovr_d;
      ie_q   <= ie_d;
      irq_q  <= irq_d;
    end
  end

  // Shifter next-state: start bit, eight data bits LSB first, stop bits
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    if (load) begin
      state_d   = START;
      shift_d   = hold_q;
      bit_cnt_d = 3'd0;
      txd_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          txd_d = 1'b1;
        end
        START: begin
          if (tick) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
            txd_d     = shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_q == 3'd7) begin
              state_d   = STOP;
              bit_cnt_d = 3'd0;
              txd_d     = 1'b1;
            end else begin
              shift_d   = {1'b0, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              txd_d     = shift_q[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_d = IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

  // Shifter registers; TXD comes straight from a flop
  always_ff @(posedge E or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

  assign TXD = txd_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_acia_tx.sv
// Self-checking bench for acia_tx with a short bit period (DIV=4, one stop bit).
module tb_acia_tx;

   localparam int DIV       = 4;
   localparam int STOP_BITS = 1;

   logic       E;
   logic       RESET;
   logic       CS;
   logic       RW;
   logic       A0;
   logic [7:0] DIN;
   logic [7:0] DOUT;
   logic       TXD;
   logic       IRQ;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       cs;
      logic       rw;
      logic       a0;
      logic [7:0] din;
      logic [7:0] expDout;
      logic       expIrq;
      logic       expTxd;
   } vec_t;

   vec_t vecs [11];

   acia_tx #(
      .DIV      (DIV),
      .STOP_BITS(STOP_BITS)
   ) dut (
      .E    (E),
      .RESET(RESET),
      .CS   (CS),
      .RW   (RW),
      .A0   (A0),
      .DIN  (DIN),
      .DOUT (DOUT),
      .TXD  (TXD),
      .IRQ  (IRQ)
   );

   // Bus clock E, 10 ns period, rising edges at 5, 15, 25 ...
   initial begin
      E = 1'b0;
      forever #5 E = ~E;
   end

   // Expected line level a given number of edges after the transfer edge
   // (0 = the transfer edge itself): DIV start cycles, 8 data bits, stop.
   function automatic logic txdAt(input int rel, input logic [7:0] b);
      int idx;
      if (rel < 0) return 1'b1;
      if (rel < DIV) return 1'b0;
      if (rel < 9 * DIV) begin
         idx = (rel - DIV) / DIV;
         return b[idx];
      end
      return 1'b1;
   endfunction

   // Drives the bus inputs for the coming edge
   task automatic applyStimulus(input logic cs, input logic rw, input logic a0, input logic [7:0] din);
      CS  = cs;
      RW  = rw;
      A0  = a0;
      DIN = din;
   endtask

   // Compares one observed value with the bench's expectation
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
      end
   endtask

   // One bus cycle: drive inputs just after an edge, sample DOUT mid-cycle,
   // then return 1 ns after the next rising edge
   task automatic busCycle(input logic cs, input logic rw, input logic a0, input logic [7:0] din,
                           output logic [7:0] doutSeen);
      applyStimulus(cs, rw, a0, din);
      #1;
      doutSeen = DOUT;
      @(posedge E);
      #1;
   endtask

   // Main sequence: reset, register table, then the multi-cycle scenarios
   initial begin
      logic [7:0] seen;
      logic [7:0] expStatus;
      logic       expLine;

      // Register-level vectors starting from reset: IE writes, IRQ lag,
      // status contents, deselected accesses and data-register reads
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h03, 1'b1, 1'b1};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h83, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h03, 1'b1, 1'b1};

      // Reset held with the clock running
      RESET = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
      repeat (3) @(posedge E);
      #1;
      checkOutput("reset txd", {7'd0, TXD}, 8'h01);
      checkOutput("reset irq", {7'd0, IRQ}, 8'h01);
      checkOutput("reset status", DOUT, 8'h03);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      @(negedge E);
      RESET = 1'b1;
      @(posedge E);
      #1;

      // Table-driven register vectors
      for (int i = 0; i < 11; i++) begin
         busCycle(vecs[i].cs, vecs[i].rw, vecs[i].a0, vecs[i].din, seen);
         checkOutput($sformatf("vec%0d dout", i), seen, vecs[i].expDout);
         checkOutput($sformatf("vec%0d irq", i), {7'd0, IRQ}, {7'd0, vecs[i].expIrq});
         checkOutput($sformatf("vec%0d txd", i), {7'd0, TXD}, {7'd0, vecs[i].expTxd});
      end

      // Single byte 8'h55: transfer one edge after the write, full frame,
      // then IDLE once the stop bit has gone out
      busCycle(1'b1, 1'b0, 1'b0, 8'h55, seen);
      for (int i = 1; i <= 42; i++) begin
         busCycle(1'b1, 1'b1, 1'b1, 8'h00, seen);
         expStatus = (i == 1) ? 8'h00 : ((i <= 41) ? 8'h01 : 8'h03);
         checkOutput($sformatf("single status i=%0d", i), seen, expStatus);
         checkOutput($sformatf("single txd i=%0d", i), {7'd0, TXD}, {7'd0, txdAt(i - 1, 8'h55)});
      end

      // Back-to-back 8'hA5 then 8'h3C: second start bit 40 cycles after
      // the first, TDRE low while the second byte waits, OVR never set
      for (int i = 0; i <= 83; i++) begin
         if (i == 0) begin
            busCycle(1'b1, 1'b0, 1'b0, 8'hA5, seen);
         end else if (i == 2) begin
            busCycle(1'b1, 1'b0, 1'b0, 8'h3C, seen);
         end else begin
            busCycle(1'b1, 1'b1, 1'b1, 8'h00, seen);
            expStatus = {6'd0, (i - 1) >= 81, ((i - 1) == 1) || ((i - 1) >= 41)};
            checkOutput($sformatf("b2b status i=%0d", i), seen, expStatus);
         end
         expLine = (i <= 40) ? txdAt(i - 1, 8'hA5) : txdAt(i - 41, 8'h3C);
         checkOutput($sformatf("b2b txd i=%0d", i), {7'd0, TXD}, {7'd0, expLine});
      end

      // Overrun: 11, 22, 33 on consecutive edges; 33 is dropped, OVR reads
      // once and clears, and only 11 and 22 appear on the line
      for (int i = 0; i <= 83; i++) begin
         if (i <= 2) begin
            busCycle(1'b1, 1'b0, 1'b0, 8'h11 * 8'(i + 1), seen);
         end else if (i <= 4 || i == 83) begin
            busCycle(1'b1, 1'b1, 1'b1, 8'h00, seen);
            expStatus = (i == 3) ? 8'h04 : ((i == 4) ? 8'h00 : 8'h03);
            checkOutput($sformatf("ovr status i=%0d", i), seen, expStatus);
         end else begin
            busCycle(1'b0, 1'b1, 1'b0, 8'h00, seen);
         end
         expLine = (i <= 40) ? txdAt(i - 1, 8'h11) : txdAt(i - 41, 8'h22);
         checkOutput($sformatf("ovr txd i=%0d", i), {7'd0, TXD}, {7'd0, expLine});
      end

      // IRQ: enable with holding empty, then a data write pulses IRQ high
      // for one cycle around the transfer, then disable
      busCycle(1'b1, 1'b0, 1'b1, 8'h01, seen);
      checkOutput("irq enable edge", {7'd0, IRQ}, 8'h01);
      busCycle(1'b0, 1'b1, 1'b0, 8'h00, seen);
      checkOutput("irq enable lag", {7'd0, IRQ}, 8'h00);
      busCycle(1'b1, 1'b0, 1'b0, 8'h77, seen);
      checkOutput("irq data write edge", {7'd0, IRQ}, 8'h00);
      busCycle(1'b0, 1'b1, 1'b0, 8'h00, seen);
      checkOutput("irq holding full", {7'd0, IRQ}, 8'h01);
      busCycle(1'b0, 1'b1, 1'b0, 8'h00, seen);
      checkOutput("irq after transfer", {7'd0, IRQ}, 8'h00);
      repeat (42) busCycle(1'b0, 1'b1, 1'b0, 8'h00, seen);
      busCycle(1'b1, 1'b1, 1'b1, 8'h00, seen);
      checkOutput("irq status pending", seen, 8'h83);
      busCycle(1'b1, 1'b0, 1'b1, 8'h00, seen);
      checkOutput("irq disable edge", {7'd0, IRQ}, 8'h00);
      busCycle(1'b0, 1'b1, 1'b0, 8'h00, seen);
      checkOutput("irq disabled", {7'd0, IRQ}, 8'h01);

      // Reset mid-frame of 8'h00 with another byte waiting in holding
      busCycle(1'b1, 1'b0, 1'b0, 8'h00, seen);
      for (int i = 1; i <= 10; i++) begin
         if (i == 2) begin
            busCycle(1'b1, 1'b0, 1'b0, 8'h00, seen);
         end else begin
            busCycle(1'b0, 1'b1, 1'b0, 8'h00, seen);
         end
      end
      checkOutput("midframe txd low", {7'd0, TXD}, 8'h00);
      #2;
      RESET = 1'b0;
      #1;
      checkOutput("midframe async txd", {7'd0, TXD}, 8'h01);
      repeat (2) @(posedge E);
      @(negedge E);
      RESET = 1'b1;
      @(posedge E);
      #1;
      for (int i = 0; i < 50; i++) begin
         busCycle(1'b0, 1'b1, 1'b0, 8'h00, seen);
         checkOutput($sformatf("post reset txd i=%0d", i), {7'd0, TXD}, 8'h01);
      end
      busCycle(1'b1, 1'b1, 1'b1, 8'h00, seen);
      checkOutput("post reset status", seen, 8'h03);
      checkOutput("post reset irq", {7'd0, IRQ}, 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
